// File: rtl/cmp_pkg.sv
// Shared definitions for the frame min/max tracker and its comparator.
// State encodings and default widths.
package cmp_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } state_t;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator: greater = (a > b), equal = (a == b).
// Ports: a, b operands; greater, equal results. Purely combinational.
module mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             greater,
  output logic             equal
);

  assign greater = (a > b);
  assign equal   = (a == b);

endmodule

// File: rtl/frame_minmax_tracker.sv
// Per-frame running max/min/first-max-index/count over a valid/ready stream.
// Ports: clk, rst; in_* sample stream; out_* held frame result.
module frame_minmax_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t state, state_nx;

  logic gt_max, eq_max;
  logic gt_min, eq_min;
  logic acc_in;
  logic cnt_full;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a       (in_data),
    .b       (out_max),
    .greater (gt_max),
    .equal   (eq_max)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a       (in_data),
    .b       (out_min),
    .greater (gt_min),
    .equal   (eq_min)
  );

  assign acc_in   = in_valid && in_ready;
  assign cnt_full = &out_count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = in_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nx = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Ties on max are ignored so the earliest index survives.
  // count saturates at all-ones, which also clamps max_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_count   <= '0;
      out_ovf     <= 1'b0;
    end else if (acc_in && state == IDLE) begin
      out_max     <= in_data;
      out_min     <= in_data;
      out_max_idx <= '0;
      out_count   <= CNT_W'(1);
      out_ovf     <= 1'b0;
    end else if (acc_in) begin
      if (gt_max) begin
        out_max     <= in_data;
        out_max_idx <= out_count;
      end
      if (!gt_min && !eq_min) out_min <= in_data;
      if (cnt_full) out_ovf   <= 1'b1;
      else          out_count <= out_count + CNT_W'(1);
    end
  end

  logic unused_eq;
  assign unused_eq = eq_max;

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Directed self-checking bench for frame_minmax_tracker.
// Default instance plus a CNT_W=4 instance sharing the same stimulus.
module tb_frame_minmax_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_max;
  logic [15:0] out_min;
  logic [15:0] out_max_idx;
  logic [15:0] out_count;
  logic        out_ovf;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_max;
  logic [15:0] s_min;
  logic [3:0]  s_idx;
  logic [3:0]  s_count;
  logic        s_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_minmax_tracker u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_min     (out_min),
    .out_max_idx (out_max_idx),
    .out_count   (out_count),
    .out_ovf     (out_ovf)
  );

  frame_minmax_tracker #(.CNT_W(4)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (s_in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (s_out_valid),
    .out_ready   (out_ready),
    .out_max     (s_max),
    .out_min     (s_min),
    .out_max_idx (s_idx),
    .out_count   (s_count),
    .out_ovf     (s_ovf)
  );

  typedef struct {
    string       name;
    int          n;
    logic [15:0] d [8];
    logic [15:0] emax;
    logic [15:0] emin;
    logic [15:0] eidx;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [15:0] mx,
                         input logic [15:0] mn, input logic [15:0] ix,
                         input logic [15:0] ct, input logic ov);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".ready"}, 32'(in_ready), 32'd0);
    chk({nm, ".max"}, 32'(out_max), 32'(mx));
    chk({nm, ".min"}, 32'(out_min), 32'(mn));
    chk({nm, ".idx"}, 32'(out_max_idx), 32'(ix));
    chk({nm, ".cnt"}, 32'(out_count), 32'(ct));
    chk({nm, ".ovf"}, 32'(out_ovf), 32'(ov));
  endtask

  task automatic send(input string nm, input logic [15:0] d,
                      input logic last);
    @(negedge clk);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{"basic", 4,
      '{16'h8040, 16'h1310, 16'h0401, 16'h8828, 0, 0, 0, 0},
      16'h8828, 16'h0401, 16'd3, 16'd4};
    vecs[1] = '{"ties", 4,
      '{16'h8080, 16'h8080, 16'h0010, 16'h8080, 0, 0, 0, 0},
      16'h8080, 16'h0010, 16'd0, 16'd4};
    vecs[2] = '{"single", 1,
      '{16'hFFFF, 0, 0, 0, 0, 0, 0, 0},
      16'hFFFF, 16'hFFFF, 16'd0, 16'd1};
    vecs[3] = '{"mixed", 4,
      '{16'h0005, 16'h0003, 16'h0009, 16'h0001, 0, 0, 0, 0},
      16'h0009, 16'h0001, 16'd2, 16'd4};
    vecs[4] = '{"zeros", 2,
      '{16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0},
      16'h0000, 16'h0000, 16'd0, 16'd2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.max", 32'(out_max), 32'd0);
    chk("rst.min", 32'(out_min), 32'd0);
    chk("rst.idx", 32'(out_max_idx), 32'd0);
    chk("rst.cnt", 32'(out_count), 32'd0);
    chk("rst.ovf", 32'(out_ovf), 32'd0);
    chk("rst.sat_cnt", 32'(s_count), 32'd0);

    // Table-driven frames, back-to-back, out_ready held high.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        send(vecs[v].name, vecs[v].d[i], i == vecs[v].n - 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk_res(vecs[v].name, vecs[v].emax, vecs[v].emin,
              vecs[v].eidx, vecs[v].ecnt, 1'b0);
      @(negedge clk);
      chk({vecs[v].name, ".valid_1cyc"}, 32'(out_valid), 32'd0);
    end

    // Reset mid-frame discards the partial frame.
    send("midrst", 16'hF000, 1'b0);
    send("midrst", 16'h0001, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.cnt0", 32'(out_count), 32'd0);
    chk("midrst.valid0", 32'(out_valid), 32'd0);
    send("midrst", 16'h0100, 1'b0);
    send("midrst", 16'h0200, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_res("midrst", 16'h0200, 16'h0100, 16'd1, 16'd2, 1'b0);

    // Backpressure with input gaps and garbage on idle cycles.
    @(negedge clk);
    out_ready = 1'b0;
    send("bp", 16'h0010, 1'b0);
    idle_cycles($urandom_range(1, 3));
    send("bp", 16'h0020, 1'b0);
    idle_cycles($urandom_range(1, 3));
    send("bp", 16'h0030, 1'b0);
    idle_cycles($urandom_range(0, 2));
    send("bp", 16'h0008, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      in_last  = 1'b1;
      chk_res("bp.hold", 16'h0030, 16'h0008, 16'd2, 16'd4, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    send("bp.next", 16'h0007, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_res("bp.next", 16'h0007, 16'h0007, 16'd0, 16'd1, 1'b0);

    // Counter saturation on the CNT_W=4 instance.
    @(negedge clk);
    for (int i = 0; i < 20; i++)
      send("sat", 16'(i), i == 19);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("sat.valid", 32'(s_out_valid), 32'd1);
    chk("sat.cnt", 32'(s_count), 32'd15);
    chk("sat.ovf", 32'(s_ovf), 32'd1);
    chk("sat.max", 32'(s_max), 32'd19);
    chk("sat.idx", 32'(s_idx), 32'd15);
    chk("sat.min", 32'(s_min), 32'd0);
    chk_res("wide", 16'd19, 16'd0, 16'd19, 16'd20, 1'b0);
    @(negedge clk);
    chk("sat.done", 32'(s_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
